fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage directly upstream of the control unit. Holds the program counter and issues instruction reads to the instruction memory/cache port. Captures each returned word into a one-entry buffer and presents it with its PC to decode over a valid/ready handshake. Also handles redirects from branch/jump resolution and stops fetching permanently once a HALT instruction has been consumed.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC loaded on reset.
- HALT_OP, 6'h3f, opcode (instr[31:26]) treated as HALT.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  out  1  instruction read request.
- iaddr  out  32  read address, always equal to the PC register.
- ihit  in  1  read data valid this cycle; only meaningful while iREN=1.
- iload  in  32  instruction word, valid with ihit.
- instr  out  32  buffered instruction to the control unit.
- instr_pc  out  32  address of `instr`.
- npc  out  32  instr_pc + 4.
- instr_valid  out  1  buffer holds an instruction.
- instr_ready  in  1  decode accepts `instr` this cycle.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address.
- halt  out  1  sticky; HALT instruction consumed.

## Operation
- Registers: pc, buf (32), buf_pc (32), state ∈ {FETCH, FULL, HALTED}.
- Transfer = instr_valid & instr_ready. Accept = iREN & ihit.
- iREN is combinational:
  - FETCH → 1.
  - FULL → instr_ready & (buf[31:26] != HALT_OP).
  - HALTED → 0.
  - Forced to 0 whenever RST=1 or redirect=1.
- On Accept: buf ← iload, buf_pc ← pc, pc ← pc + 4. Wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Transitions (checked in priority order):
  - RST → FETCH. pc=PC_INIT, buf=0, buf_pc=0, halt=0.
  - redirect in FETCH or FULL → FETCH. pc ← redirect_pc; buffer invalidated. Any ihit that cycle is discarded. A Transfer that cycle still counts as consumed by decode.
  - redirect in HALTED → ignored.
  - FETCH & Accept → FULL.
  - FULL & Transfer & buf[31:26]==HALT_OP → HALTED, halt ← 1.
  - FULL & Transfer & Accept → FULL with the new word (back-to-back).
  - FULL & Transfer & !Accept → FETCH.
  - FULL & !Transfer → FULL. Buffer is held and iREN=0.
- HALTED: instr_valid=0 and halt=1 until RST. The HALT word remains on instr.
- Outputs are registered, except iREN (combinational) and iaddr (equal to pc).
- instr_valid = (state==FULL). instr=buf. instr_pc=buf_pc. npc=buf_pc+4 (wraps).

## Timing
- Reset values: iREN=0 (while RST=1), iaddr=PC_INIT, instr=0, instr_pc=0, npc=4, instr_valid=0, halt=0.
- First iREN=1 occurs in the first cycle after RST falls.
- Latency: ihit in cycle N gives instr_valid=1 in cycle N+1.
- Throughput: one instruction per cycle while ihit and instr_ready are both held high.
- Each memory miss cycle (iREN=1, ihit=0) adds one cycle. iaddr is stable while waiting.
- instr, instr_pc and npc are stable while instr_valid=1 and instr_ready=0.
- redirect in cycle N gives iaddr=redirect_pc in N+1 with iREN=1 and instr_valid=0. The earliest valid redirected instruction appears in N+2.
- Simultaneous redirect+ihit: ihit is dropped (iREN was forced low).
- Simultaneous redirect+Transfer: the old instruction is consumed and nothing else is delivered.
- RST mid-operation (any state): full reset next cycle, including leaving HALTED.

## Test plan
- Reset and first fetch: RST high 2 cycles, then low, ihit=1, iload=32'h2001_0005, ready=1. Expect iaddr=0 with iREN=1 in the first cycle. Next cycle: instr=32'h2001_0005, instr_pc=0, npc=4, instr_valid=1.
- Streaming: ihit and ready held high for 8 cycles. Expect instr_pc sequence 0,4,…,28 on consecutive cycles with no bubbles.
- Backpressure and miss: ready=0 for 3 cycles while valid. Expect instr/instr_pc unchanged and iREN=0. Then ihit=0 for 2 cycles with ready=1. Expect instr_valid=0 and iaddr held at the same value.
- Redirect: redirect=1, redirect_pc=32'h0000_0100, with ihit=1 in the same cycle. Expect the ihit dropped, next iaddr=0x100, and the next delivered instr_pc=0x100.
- Halt: deliver 32'hFC00_0000 at instr_pc 0x8 and consume it. Expect halt=1 next cycle and iREN=0, instr_valid=0 thereafter. redirect=1 in HALTED → no change. RST → halt=0, iaddr=PC_INIT.
- Wrap: redirect_pc=32'hFFFF_FFFC, ihit=1. Expect instr_pc=32'hFFFF_FFFC, npc=0, and next iaddr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to the instruction port,
// buffers one returned word and hands it to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP = 6'h3f
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] npc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halt
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_FULL   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_buf_pc;
    logic [31:0] r_npc;
    logic        r_instr_valid;
    logic        r_halt;

    logic        w_iren;
    logic        w_accept;
    logic        w_transfer;
    logic        w_buf_is_halt;

    assign w_buf_is_halt = (r_buf[31:26] == HALT_OP);
    assign w_transfer    = (r_state == ST_FULL) && instr_ready;
    assign w_accept      = w_iren && ihit;

    // Read request: a full buffer only refetches when it drains this cycle,
    // and never behind a HALT word.
    always_comb begin
        w_iren = 1'b0;
        if (RST || redirect) begin
            w_iren = 1'b0;
        end else begin
            case (r_state)
                ST_FETCH:  w_iren = 1'b1;
                ST_FULL:   w_iren = instr_ready && !w_buf_is_halt;
                ST_HALTED: w_iren = 1'b0;
                default:   w_iren = 1'b0;
            endcase
        end
    end

    // State, PC and one-entry instruction buffer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= ST_FETCH;
            r_pc          <= PC_INIT;
            r_buf         <= 32'h0000_0000;
            r_buf_pc      <= 32'h0000_0000;
            r_npc         <= 32'h0000_0004;
            r_instr_valid <= 1'b0;
            r_halt        <= 1'b0;
        end else if (redirect && (r_state != ST_HALTED)) begin
            r_state       <= ST_FETCH;
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_accept) begin
                        r_buf         <= iload;
                        r_buf_pc      <= r_pc;
                        r_npc         <= r_pc + 32'd4;
                        r_pc          <= r_pc + 32'd4;
                        r_state       <= ST_FULL;
                        r_instr_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_transfer) begin
                        if (w_buf_is_halt) begin
                            r_state       <= ST_HALTED;
                            r_instr_valid <= 1'b0;
                            r_halt        <= 1'b1;
                        end else if (w_accept) begin
                            r_buf         <= iload;
                            r_buf_pc      <= r_pc;
                            r_npc         <= r_pc + 32'd4;
                            r_pc          <= r_pc + 32'd4;
                            r_state       <= ST_FULL;
                            r_instr_valid <= 1'b1;
                        end else begin
                            r_state       <= ST_FETCH;
                            r_instr_valid <= 1'b0;
                        end
                    end
                end
                ST_HALTED: begin
                    r_state       <= ST_HALTED;
                    r_instr_valid <= 1'b0;
                    r_halt        <= 1'b1;
                end
                default: begin
                    r_state       <= ST_FETCH;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign iREN        = w_iren;
    assign iaddr       = r_pc;
    assign instr       = r_buf;
    assign instr_pc    = r_buf_pc;
    assign npc         = r_npc;
    assign instr_valid = r_instr_valid;
    assign halt        = r_halt;

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-vector bench for fetch_unit with a scoreboard of fetched words.
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] npc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    fetch_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .ihit        (ihit),
        .iload       (iload),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .npc         (npc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        rst;
        logic        ihit;
        logic [31:0] iload;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_iren;
        logic [31:0] e_iaddr;
        logic        e_valid;
        logic        e_halt;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } exp_t;

    localparam int NV = 34;
    vec_t vecs[NV];
    exp_t sbq[$];
    int total;
    int bad;
    logic [31:0] last_word;

    function automatic vec_t mk(input logic rst, input logic ih, input logic [31:0] ld,
                                input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic ei, input logic [31:0] ea,
                                input logic ev, input logic eh);
        vec_t v;
        v.rst = rst; v.ihit = ih; v.iload = ld; v.rdy = rdy; v.redir = rd; v.rpc = rpc;
        v.e_iren = ei; v.e_iaddr = ea; v.e_valid = ev; v.e_halt = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        last_word = 32'h0000_0000;
        RST = 1'b1; ihit = 1'b0; iload = 32'h0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;

        //                 rst   ihit  iload          rdy   redir rpc           iren  iaddr          valid halt
        vecs[0]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 32'h2001_0005, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 1'b0);
        for (int k = 2; k <= 9; k++)
            vecs[k] = mk(1'b0, 1'b1, 32'h1000_0000 + 32'(k), 1'b1, 1'b0, 32'h0,
                         1'b1, 32'(4 * (k - 1)), 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 32'h3333_0001, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0024, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 32'h3333_0002, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0024, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 32'h3333_0003, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0024, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0024, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0024, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0024, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 32'h4444_0024, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0024, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0028, 1'b1, 1'b0);
        vecs[18] = mk(1'b0, 1'b1, 32'h6666_0100, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0104, 1'b1, 1'b0);
        vecs[20] = mk(1'b0, 1'b1, 32'hFC00_0000, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 1'b0);
        vecs[21] = mk(1'b0, 1'b1, 32'h8888_0001, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_000C, 1'b1, 1'b0);
        vecs[22] = mk(1'b0, 1'b1, 32'h8888_0002, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_000C, 1'b1, 1'b0);
        vecs[23] = mk(1'b0, 1'b1, 32'h8888_0003, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_000C, 1'b0, 1'b1);
        vecs[24] = mk(1'b0, 1'b1, 32'h8888_0004, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_000C, 1'b0, 1'b1);
        vecs[25] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_000C, 1'b0, 1'b1);
        vecs[26] = mk(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_000C, 1'b0, 1'b1);
        vecs[27] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 1'b0);
        vecs[28] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        vecs[29] = mk(1'b0, 1'b1, 32'h9999_FFFC, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        vecs[30] = mk(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b1, 1'b0);
        vecs[31] = mk(1'b0, 1'b1, 32'hAAAA_0000, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 1'b0);
        vecs[32] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b1, 1'b0);
        vecs[33] = mk(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 1'b0);

        repeat (2) @(posedge CLK);

        for (int i = 0; i < NV; i++) begin
            @(posedge CLK);
            #1;
            RST = vecs[i].rst; ihit = vecs[i].ihit; iload = vecs[i].iload;
            instr_ready = vecs[i].rdy; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
            #4;
            chk($sformatf("row%0d iREN", i), {31'd0, iREN}, {31'd0, vecs[i].e_iren});
            chk($sformatf("row%0d iaddr", i), iaddr, vecs[i].e_iaddr);
            chk($sformatf("row%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("row%0d halt", i), {31'd0, halt}, {31'd0, vecs[i].e_halt});
            if (i == 0) begin
                chk("reset instr", instr, 32'h0000_0000);
                chk("reset instr_pc", instr_pc, 32'h0000_0000);
                chk("reset npc", npc, 32'h0000_0004);
            end
            if (vecs[i].e_valid) begin
                if (sbq.size() == 0) begin
                    total = total + 1;
                    bad = bad + 1;
                    $display("FAIL row%0d scoreboard: got empty queue want entry", i);
                end else begin
                    chk($sformatf("row%0d instr", i), instr, sbq[0].w);
                    chk($sformatf("row%0d instr_pc", i), instr_pc, sbq[0].pc);
                    chk($sformatf("row%0d npc", i), npc, sbq[0].pc + 32'd4);
                    if (vecs[i].rdy) begin
                        last_word = sbq[0].w;
                        void'(sbq.pop_front());
                    end
                end
            end
            if (vecs[i].e_halt)
                chk($sformatf("row%0d halted instr", i), instr, last_word);
            if (vecs[i].redir)
                sbq.delete();
            if (vecs[i].e_iren && vecs[i].ihit)
                sbq.push_back('{w: vecs[i].iload, pc: vecs[i].e_iaddr});
        end

        chk("scoreboard drained", 32'(sbq.size()), 32'd0);

        // Reset taken while the buffer is full.
        @(posedge CLK); #1;
        RST = 1'b0; ihit = 1'b1; iload = 32'hBBBB_0004; instr_ready = 1'b0; redirect = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1; ihit = 1'b1;
        #4;
        chk("full before rst valid", {31'd0, instr_valid}, 32'd1);
        chk("rst forces iREN low", {31'd0, iREN}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0; ihit = 1'b0;
        #4;
        chk("rst from full valid", {31'd0, instr_valid}, 32'd0);
        chk("rst from full iaddr", iaddr, 32'h0000_0000);
        chk("rst from full instr", instr, 32'h0000_0000);
        chk("rst from full npc", npc, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
